// File: rtl/rv32_pkg.sv
// Shared RV32I core definitions.
//   XLEN          - architectural register/PC width
//   PC_STEP       - sequential fetch increment in bytes
//   RV_NOP        - canonical NOP encoding (addi x0, x0, 0)
//   fetch_entry_t - {pc, instr} pair carried from fetch to decode
package rv32_pkg;

   localparam int unsigned     XLEN    = 32;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;
   localparam logic [XLEN-1:0] RV_NOP  = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO used as the fetch buffer.
// Parameters: DEPTH (power of two, >= 2), WIDTH (entry width in bits).
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   flush      - empties the FIFO; overrides push and pop
//   push, din  - write din at the tail (caller guarantees not full unless popping)
//   pop        - drop the head entry (caller guarantees not empty)
//   count      - number of valid entries (0..DEPTH)
//   head       - contents of the head entry (undefined when count == 0)
module fetch_fifo #(
   parameter int unsigned  DEPTH = 2,
   parameter int unsigned  WIDTH = 64,
   localparam int unsigned PW    = $clog2(DEPTH),
   localparam int unsigned CW    = PW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [CW-1:0]    count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   // Pointers are exactly log2(DEPTH) bits, so +1 wraps at DEPTH by itself.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only observed when count != 0.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= din;
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage.
// Owns the PC, fetches from a combinational imem, buffers {pc, instr} in fetch_fifo and
// hands entries to decode over a valid/ready handshake. Redirects flush the buffer.
// Optional feature (macro FETCH_MISALIGN_TRAP_EN): a misaligned redirect halts fetch and
// raises if_trap until the next aligned redirect; without it the low PC bits are cleared.
// Ports:
//   clk, rst_n                  - clock and asynchronous active-low reset
//   imem_addr / imem_instr      - imem byte address (== pc) and returned word
//   redirect_valid, redirect_pc - redirect request and target
//   if_valid, if_ready          - handshake toward decode
//   if_pc, if_instr             - head entry (zero while if_valid == 0)
//   if_trap                     - misaligned-redirect trap (macro builds only)
module fetch_unit
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic        if_trap,
`endif
   output logic [31:0] if_instr
);

   localparam int unsigned     CW         = $clog2(FIFO_DEPTH) + 1;
   localparam logic [XLEN-1:0] ALIGN_MASK = ~32'h3;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] redirect_target;
   logic [CW-1:0]   count;
   fetch_entry_t    head, tail;
   logic            pop, push, halt, fifo_full;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic halt_q, halt_d;

   // Misaligned target is kept as-is so the faulting address shows on imem_addr.
   assign redirect_target = redirect_pc;
   assign halt_d          = redirect_valid ? (redirect_pc[1:0] != 2'b00) : halt_q;
   assign halt            = halt_q;
   assign if_trap         = halt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) halt_q <= 1'b0;
      else        halt_q <= halt_d;
   end
`else
   assign redirect_target = redirect_pc & ALIGN_MASK;
   assign halt            = 1'b0;
`endif

   assign fifo_full = (count == CW'(FIFO_DEPTH));
   assign pop       = if_valid & if_ready;
   assign push      = ~redirect_valid & (~fifo_full | pop) & ~halt;
   assign tail      = '{pc: pc_q, instr: imem_instr};

   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) pc_d = redirect_target;
      else if (push)      pc_d = pc_q + PC_STEP;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   // Redirect flushes; a pop in the same cycle is accepted by decode but has no effect here.
   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_valid),
      .push  (push),
      .pop   (pop),
      .din   (tail),
      .count (count),
      .head  (head)
   );

   assign imem_addr = pc_q;
   assign if_valid  = (count != '0);
   assign if_pc     = if_valid ? head.pc    : '0;
   assign if_instr  = if_valid ? head.instr : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized ready/redirect traffic.
// The stimulus side predicts the instruction stream decode should see and queues it; a monitor
// compares every accepted handshake against that queue.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int unsigned WINDOW   = 256;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        if_trap;
`endif

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   pops   = 0;

   always #5 clk = ~clk;

   // Memory content: an address-unique word (odd multiplier is a bijection on 32 bits).
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
   endfunction

   assign imem_instr = mem_word(imem_addr);

   fetch_unit #(
      .RESET_PC   (RESET_PC),
      .FIFO_DEPTH (2)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
      .if_trap        (if_trap),
`endif
      .if_instr       (if_instr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Decode must see start, start+4, ... until the next redirect or reset.
   task automatic expect_stream(input logic [31:0] start);
      logic [31:0] a;
      exp_q.delete();
      a = start;
      for (int i = 0; i < WINDOW; i++) begin
         exp_q.push_back('{pc: a, instr: mem_word(a)});
         a = a + 32'd4;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_redirect(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (target[1:0] != 2'b00) exp_q.delete();
      else                      expect_stream(target);
`else
      expect_stream({target[31:2], 2'b00});
`endif
   endtask

   // Monitor: inputs change just after posedge, so at negedge both sides are settled.
   always @(negedge clk) begin
      if (rst_n && if_valid && if_ready && !redirect_valid) begin
         pops++;
         if (exp_q.size() == 0) begin
            check("unexpected_entry", if_pc, 32'hxxxx_xxxx);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("stream_pc", if_pc, e.pc);
            check("stream_instr", if_instr, e.instr);
         end
      end
   end

   initial begin
      int p0;
      int since;
      rst_n          = 1'b0;
      if_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      repeat (2) step();

      check("rst_valid", {31'd0, if_valid}, 32'd0);
      check("rst_addr", imem_addr, RESET_PC);
      check("rst_if_pc", if_pc, 32'd0);
      check("rst_if_instr", if_instr, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("rst_trap", {31'd0, if_trap}, 32'd0);
`endif

      // Stall: buffer fills to 2 and the PC freezes two words ahead.
      expect_stream(RESET_PC);
      rst_n = 1'b1;
      repeat (3) step();
      check("stall_addr", imem_addr, RESET_PC + 32'h8);
      check("stall_valid", {31'd0, if_valid}, 32'd1);
      check("stall_head", if_pc, RESET_PC);

      // Release: one instruction per cycle.
      if_ready = 1'b1;
      p0 = pops;
      repeat (10) step();
      check("throughput", pops - p0, 32'd10);

      // Redirect with a full buffer.
      if_ready = 1'b0;
      repeat (2) step();
      issue_redirect(32'h40);
      step();
      redirect_valid = 1'b0;
      check("redir_valid", {31'd0, if_valid}, 32'd0);
      check("redir_addr", imem_addr, 32'h40);
      if_ready = 1'b1;
      step();
      check("redir_head_pc", if_pc, 32'h40);
      check("redir_head_instr", if_instr, mem_word(32'h40));
      repeat (5) step();

      // PC wrap at the top of the address space.
      issue_redirect(32'hFFFF_FFFC);
      step();
      redirect_valid = 1'b0;
      step();
      check("wrap_top", if_pc, 32'hFFFF_FFFC);
      step();
      check("wrap_zero", if_pc, 32'h0);
      repeat (3) step();

      // Misaligned redirect.
      issue_redirect(32'h23);
      step();
      redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      check("trap_set", {31'd0, if_trap}, 32'd1);
      check("trap_valid", {31'd0, if_valid}, 32'd0);
      check("trap_addr", imem_addr, 32'h23);
      repeat (3) step();
      check("trap_halt_valid", {31'd0, if_valid}, 32'd0);
      check("trap_halt_addr", imem_addr, 32'h23);
      issue_redirect(32'h10);
      step();
      redirect_valid = 1'b0;
      check("trap_clear", {31'd0, if_trap}, 32'd0);
      step();
      check("trap_resume", if_pc, 32'h10);
`else
      step();
      check("misalign_forced", if_pc, 32'h20);
`endif
      repeat (3) step();

      // Reset mid-stream with a full buffer.
      if_ready = 1'b0;
      repeat (3) step();
      rst_n = 1'b0;
      expect_stream(RESET_PC);
      #1;
      check("midrst_valid", {31'd0, if_valid}, 32'd0);
      check("midrst_addr", imem_addr, RESET_PC);
      step();
      rst_n    = 1'b1;
      if_ready = 1'b1;
      step();
      check("midrst_restart", if_pc, RESET_PC);
      repeat (3) step();

      // Random traffic.
      p0    = pops;
      since = 0;
      for (int i = 0; i < 3000; i++) begin
         if_ready = ($urandom_range(0, 9) < 7);
         if (since > 150 || $urandom_range(0, 99) < 4) begin
            logic [31:0] t;
            t = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            t[1:0] = 2'b00;
`endif
            issue_redirect(t);
            since = 0;
         end else begin
            redirect_valid = 1'b0;
            since++;
         end
         step();
      end
      redirect_valid = 1'b0;
      if_ready       = 1'b0;
      step();
      check("random_progress", {31'd0, (pops - p0) > 1000}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
